// File: rtl/tl_pkg.sv
// Shared definitions for the TileLink A-channel FIFO writer: opcodes, burst state, packed-beat layout.
// TL_A_PARITY_EN adds an even-parity MSB to the packed beat.
package tl_pkg;

    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET         = 3'd4;

    localparam int unsigned OPC_W   = 3;
    localparam int unsigned PARAM_W = 3;

`ifdef TL_A_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    // Beats spanned by a request; only Put bursts wider than one beat are multi-beat.
    function automatic int unsigned beat_count(input logic [2:0] opcode,
                                               input int unsigned size,
                                               input int unsigned bpb);
        if (((opcode == PUT_FULL) || (opcode == PUT_PARTIAL)) && (size > bpb))
            return 32'(1) << (size - bpb);
        return 1;
    endfunction

    function automatic int unsigned mask_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned data_w);
        return mask_lsb(data_w) + data_w / 8;
    endfunction

    function automatic int unsigned source_lsb(input int unsigned data_w, input int unsigned addr_w);
        return addr_lsb(data_w) + addr_w;
    endfunction

    function automatic int unsigned size_lsb(input int unsigned data_w, input int unsigned addr_w,
                                             input int unsigned src_w);
        return source_lsb(data_w, addr_w) + src_w;
    endfunction

    function automatic int unsigned param_lsb(input int unsigned data_w, input int unsigned addr_w,
                                              input int unsigned src_w, input int unsigned size_w);
        return size_lsb(data_w, addr_w, src_w) + size_w;
    endfunction

    function automatic int unsigned opcode_lsb(input int unsigned data_w, input int unsigned addr_w,
                                               input int unsigned src_w, input int unsigned size_w);
        return param_lsb(data_w, addr_w, src_w, size_w) + PARAM_W;
    endfunction

    function automatic int unsigned first_bit(input int unsigned data_w, input int unsigned addr_w,
                                              input int unsigned src_w, input int unsigned size_w);
        return opcode_lsb(data_w, addr_w, src_w, size_w) + OPC_W;
    endfunction

    function automatic int unsigned last_bit(input int unsigned data_w, input int unsigned addr_w,
                                             input int unsigned src_w, input int unsigned size_w);
        return first_bit(data_w, addr_w, src_w, size_w) + 1;
    endfunction

    function automatic int unsigned pkt_width(input int unsigned data_w, input int unsigned addr_w,
                                              input int unsigned src_w, input int unsigned size_w);
        return last_bit(data_w, addr_w, src_w, size_w) + 1 + PAR_W;
    endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// Two-entry skid buffer (OUT + SKID) with a registered in_ready, sustaining one beat per cycle.
module tl_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             wr_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_n;
    logic             skid_valid_q, skid_valid_n;
    logic [WIDTH-1:0] out_q, out_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             ready_q, ready_n;
    logic             accept, drain;

    assign accept = in_valid && ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_valid_n  = out_valid_q;
        skid_valid_n = skid_valid_q;
        out_n        = out_q;
        skid_n       = skid_q;
        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                // SKID refills OUT; a simultaneous arrival takes the vacated SKID slot.
                out_n        = skid_q;
                out_valid_n  = 1'b1;
                skid_valid_n = accept;
                if (accept)
                    skid_n = in_data;
            end else begin
                out_valid_n = accept;
                if (accept)
                    out_n = in_data;
            end
        end else if (accept) begin
            skid_n       = in_data;
            skid_valid_n = 1'b1;
        end
        ready_n = !(out_valid_n && skid_valid_n);
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_n;
            skid_valid_q <= skid_valid_n;
            out_q        <= out_n;
            skid_q       <= skid_n;
            ready_q      <= ready_n;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/tl_a_fifo_writer.sv
// TileLink A-channel feeder for the write side of the async FIFO: burst tagging, packing, skid buffering.
// Build with TL_A_PARITY_EN to prepend an even-parity bit to every packed beat.
//
//  state    | meaning
//  ST_IDLE  | next accepted beat is a burst head (first=1)
//  ST_BURST | inside a multi-beat Put, rem beats still to come
module tl_a_fifo_writer
    import tl_pkg::*;
#(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned SRC_W  = 4,
    parameter  int unsigned SIZE_W = 3,
    localparam int unsigned MASK_W = DATA_W / 8,
    localparam int unsigned PKT_W  = pkt_width(DATA_W, ADDR_W, SRC_W, SIZE_W)
) (
    input  logic              wr_clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_param,
    input  logic [SIZE_W-1:0] a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [MASK_W-1:0] a_mask,
    input  logic [DATA_W-1:0] a_data,
    output logic              fifo_wr_en,
    output logic [PKT_W-1:0]  fifo_wr_data,
    input  logic              fifo_full,
    output logic              burst_err,
    output logic [15:0]       beat_cnt
);

    localparam int unsigned BPB    = $clog2(MASK_W);
    localparam int unsigned CNT_W  = 2 ** SIZE_W;
    localparam int unsigned BODY_W = last_bit(DATA_W, ADDR_W, SRC_W, SIZE_W) + 1;

    burst_state_e      state, state_n;
    logic [CNT_W-1:0]  rem, rem_n;
    logic [2:0]        head_opcode, head_opcode_n;
    logic [SIZE_W-1:0] head_size, head_size_n;
    logic [SRC_W-1:0]  head_source, head_source_n;
    logic              err_set;
    logic              first, last;
    logic              accept;
    logic              out_valid;
    int unsigned       beats;
    logic [BODY_W-1:0] pkt_body;
    logic [PKT_W-1:0]  pkt;

    assign accept = a_valid && a_ready;

    always_comb begin
        state_n       = state;
        rem_n         = rem;
        head_opcode_n = head_opcode;
        head_size_n   = head_size;
        head_source_n = head_source;
        err_set       = 1'b0;
        first         = 1'b1;
        last          = 1'b1;
        beats         = beat_count(a_opcode, 32'(a_size), BPB);
        case (state)
            ST_IDLE: begin
                first = 1'b1;
                if (beats > 1) begin
                    last = 1'b0;
                    if (accept) begin
                        rem_n         = CNT_W'(beats - 1);
                        state_n       = ST_BURST;
                        head_opcode_n = a_opcode;
                        head_size_n   = a_size;
                        head_source_n = a_source;
                    end
                end
            end
            ST_BURST: begin
                first = 1'b0;
                last  = (rem == CNT_W'(1));
                if (accept) begin
                    rem_n = rem - CNT_W'(1);
                    if (rem == CNT_W'(1))
                        state_n = ST_IDLE;
                    // A mismatched beat is flagged but still packed; the burst runs to completion.
                    if ((a_opcode != head_opcode) || (a_size != head_size) ||
                        (a_source != head_source))
                        err_set = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rem         <= '0;
            head_opcode <= '0;
            head_size   <= '0;
            head_source <= '0;
            burst_err   <= 1'b0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            head_opcode <= head_opcode_n;
            head_size   <= head_size_n;
            head_source <= head_source_n;
            if (err_set)
                burst_err <= 1'b1;
        end
    end

    assign pkt_body = {last, first, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};

`ifdef TL_A_PARITY_EN
    assign pkt = {^pkt_body, pkt_body};
`else
    assign pkt = pkt_body;
`endif

    tl_skid_buf #(
        .WIDTH (PKT_W)
    ) u_skid (
        .wr_clk    (wr_clk),
        .reset     (reset),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_data   (pkt),
        .out_valid (out_valid),
        .out_ready (!fifo_full),
        .out_data  (fifo_wr_data)
    );

    assign fifo_wr_en = out_valid && !fifo_full;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset)
            beat_cnt <= '0;
        else if (fifo_wr_en)
            beat_cnt <= beat_cnt + 16'd1;
    end

endmodule

// File: tb/tb_tl_a_fifo_writer.sv
// Scoreboard bench for tl_a_fifo_writer: directed beats push expected words, a monitor pops on each FIFO push.
module tb_tl_a_fifo_writer;

`ifdef TL_A_PARITY_EN
    localparam int PKT_W = 84;
`else
    localparam int PKT_W = 83;
`endif
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    logic             wr_clk = 1'b0;
    logic             reset;
    logic             a_valid;
    logic             a_ready;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [2:0]       a_size;
    logic [3:0]       a_source;
    logic [31:0]      a_address;
    logic [3:0]       a_mask;
    logic [31:0]      a_data;
    logic             fifo_wr_en;
    logic [PKT_W-1:0] fifo_wr_data;
    logic             fifo_full;
    logic             burst_err;
    logic [15:0]      beat_cnt;

    tl_a_fifo_writer dut (
        .wr_clk       (wr_clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_opcode     (a_opcode),
        .a_param      (a_param),
        .a_size       (a_size),
        .a_source     (a_source),
        .a_address    (a_address),
        .a_mask       (a_mask),
        .a_data       (a_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .burst_err    (burst_err),
        .beat_cnt     (beat_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    int cyc = 0;
    always @(posedge wr_clk) cyc <= cyc + 1;

    logic [PKT_W-1:0] exp_q[$];
    int               push_cyc[$];
    logic [PKT_W-1:0] last_word;
    int               checks = 0;
    int               errors = 0;
    int               acc_cyc = 0;
    int               idx = 0;

    function automatic logic [PKT_W-1:0] pack(input bit last, input bit first, input logic [2:0] opc,
                                              input logic [2:0] size, input logic [3:0] src,
                                              input logic [31:0] addr, input logic [3:0] mask,
                                              input logic [31:0] data);
        logic [82:0] body;
        body = {last, first, opc, 3'd0, size, src, addr, mask, data};
`ifdef TL_A_PARITY_EN
        return {^body, body};
`else
        return body;
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge wr_clk);
            if (!reset && fifo_wr_en) begin
                push_cyc.push_back(cyc);
                last_word = fifo_wr_data;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_push actual=%0h required=none", fifo_wr_data);
                end else begin
                    chk("push_word", fifo_wr_data, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] opc, input logic [2:0] size, input logic [3:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        a_valid   = 1'b1;
        a_opcode  = opc;
        a_param   = 3'd0;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
    endtask

    // Holds the beat until a_ready is seen before an edge; the expected word is queued on acceptance.
    task automatic send(input logic [2:0] opc, input logic [2:0] size, input logic [3:0] src,
                        input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input bit first, input bit last);
        bit ok;
        drive(opc, size, src, addr, mask, data);
        for (int n = 0; n < 60; n++) begin
            @(negedge wr_clk);
            ok = a_ready;
            step();
            if (ok) begin
                exp_q.push_back(pack(last, first, opc, size, src, addr, mask, data));
                acc_cyc = cyc;
                a_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=not_ready required=ready");
        a_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 30 && exp_q.size() != 0; n++)
            step();
        step();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_param   = '0;
        a_size    = '0;
        a_source  = '0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        fifo_full = 1'b0;
        fork
            monitor();
        join_none

        // Reset state and the one-edge delay before a_ready rises
        repeat (2) step();
        @(negedge wr_clk);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_burst_err", burst_err, 0);
        step();
        reset = 1'b0;
        @(negedge wr_clk);
        chk("ready_before_edge", a_ready, 0);
        step();
        @(negedge wr_clk);
        chk("ready_after_edge", a_ready, 1);
        step();

        // 1: single Get
        idx = push_cyc.size();
        send(OP_GET, 3'd2, 4'd1, 32'h0000_0040, 4'hF, 32'hAAAA_5555, 1'b1, 1'b1);
        drain("t1_drain");
        chk("t1_push_count", push_cyc.size() - idx, 1);
        chk("t1_latency", push_cyc[idx], acc_cyc);
        @(negedge wr_clk);
        chk("t1_beat_cnt", beat_cnt, 16'd1);
        step();

        // 2: 4-beat PutFull back to back
        idx = push_cyc.size();
        send(OP_PUT_FULL, 3'd4, 4'd2, 32'h0000_0100, 4'hF, 32'h1111_0000, 1'b1, 1'b0);
        send(OP_PUT_FULL, 3'd4, 4'd2, 32'h0000_0104, 4'hF, 32'h2222_0001, 1'b0, 1'b0);
        send(OP_PUT_FULL, 3'd4, 4'd2, 32'h0000_0108, 4'hF, 32'h3333_0002, 1'b0, 1'b0);
        send(OP_PUT_FULL, 3'd4, 4'd2, 32'h0000_010C, 4'hF, 32'h4444_0003, 1'b0, 1'b1);
        drain("t2_drain");
        chk("t2_push_count", push_cyc.size() - idx, 4);
        chk("t2_consecutive", push_cyc[idx+3] - push_cyc[idx], 3);
        @(negedge wr_clk);
        chk("t2_beat_cnt", beat_cnt, 16'd5);
        step();

        // 3: FIFO full for 5 edges while streaming a PutPartial burst
        fifo_full = 1'b1;
        send(OP_PUT_PARTIAL, 3'd4, 4'd7, 32'h0000_0200, 4'h3, 32'h5555_0000, 1'b1, 1'b0);
        send(OP_PUT_PARTIAL, 3'd4, 4'd7, 32'h0000_0204, 4'hC, 32'h6666_0001, 1'b0, 1'b0);
        drive(OP_PUT_PARTIAL, 3'd4, 4'd7, 32'h0000_0208, 4'h1, 32'h7777_0002);
        for (int n = 0; n < 3; n++) begin
            @(negedge wr_clk);
            chk("t3_ready_low", a_ready, 0);
            chk("t3_no_push", fifo_wr_en, 0);
            step();
        end
        fifo_full = 1'b0;
        send(OP_PUT_PARTIAL, 3'd4, 4'd7, 32'h0000_0208, 4'h1, 32'h7777_0002, 1'b0, 1'b0);
        send(OP_PUT_PARTIAL, 3'd4, 4'd7, 32'h0000_020C, 4'h8, 32'h8888_0003, 1'b0, 1'b1);
        drain("t3_drain");
        @(negedge wr_clk);
        chk("t3_beat_cnt", beat_cnt, 16'd9);
        step();

        // 4: source changes on beat 2 of a burst
        send(OP_PUT_FULL, 3'd4, 4'd3, 32'h0000_0300, 4'hF, 32'hA000_0000, 1'b1, 1'b0);
        send(OP_PUT_FULL, 3'd4, 4'd3, 32'h0000_0304, 4'hF, 32'hA000_0001, 1'b0, 1'b0);
        @(negedge wr_clk);
        chk("t4_err_before", burst_err, 0);
        step();
        send(OP_PUT_FULL, 3'd4, 4'd5, 32'h0000_0308, 4'hF, 32'hA000_0002, 1'b0, 1'b0);
        send(OP_PUT_FULL, 3'd4, 4'd3, 32'h0000_030C, 4'hF, 32'hA000_0003, 1'b0, 1'b1);
        @(negedge wr_clk);
        chk("t4_err_set", burst_err, 1);
        step();
        send(OP_GET, 3'd2, 4'd6, 32'h0000_0310, 4'hF, 32'hB000_0000, 1'b1, 1'b1);
        drain("t4_drain");
        @(negedge wr_clk);
        chk("t4_err_sticky", burst_err, 1);
        chk("t4_beat_cnt", beat_cnt, 16'd14);
        step();

        // 5: reset mid-burst with SKID occupied
        fifo_full = 1'b1;
        send(OP_PUT_FULL, 3'd4, 4'd1, 32'h0000_0400, 4'hF, 32'hC000_0000, 1'b1, 1'b0);
        send(OP_PUT_FULL, 3'd4, 4'd1, 32'h0000_0404, 4'hF, 32'hC000_0001, 1'b0, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        @(negedge wr_clk);
        chk("t5_rst_ready", a_ready, 0);
        chk("t5_rst_wr_en", fifo_wr_en, 0);
        chk("t5_rst_beat_cnt", beat_cnt, 0);
        chk("t5_rst_err", burst_err, 0);
        step();
        fifo_full = 1'b0;
        reset = 1'b0;
        step();
        send(OP_GET, 3'd2, 4'd4, 32'h0000_0500, 4'hF, 32'hD000_0000, 1'b1, 1'b1);
        drain("t5_drain");
        @(negedge wr_clk);
        chk("t5_beat_cnt", beat_cnt, 16'd1);
        step();

`ifdef TL_A_PARITY_EN
        // 6: parity over a word with exactly three ones
        send(3'd0, 3'd0, 4'd0, 32'h0, 4'h0, 32'h0000_0001, 1'b1, 1'b1);
        drain("t6_drain");
        chk("t6_parity_msb", last_word[PKT_W-1], 1);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
